fifo_rd_drain: RTL and testbench



---
 rtl/fifo_rd_drain.sv | 119 +++++++++++
 tb/tb_fifo_rd_drain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-side FIFO consumer with 2-entry skid buffer and enable/drain FSM
// Optional pop counter: define FIFO_RD_POP_CNT_EN to add the pop_cnt port.

module fifo_rd_drain #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          rclk,
    input  logic          reset_r_n,
    input  logic          en,
    input  logic          empty,
    input  logic [DW-1:0] rdata,
    output logic          pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          idle
`ifdef FIFO_RD_POP_CNT_EN
    ,
    output logic [CW-1:0] pop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    occ;
    logic [1:0]    occ_next;
    logic [DW-1:0] buf_head;
    logic [DW-1:0] buf_tail;
    logic          hs;

    // pop is a function of registered state and the registered FIFO flag only,
    // so downstream ready never reaches the FIFO pop combinationally.
    always_comb begin
        pop       = (state == RUN) && !empty && (occ != 2'd2);
        out_valid = (occ != 2'd0);
        out_data  = buf_head;
        hs        = out_valid && out_ready;
        idle      = (state == IDLE);
    end

    always_comb begin
        occ_next = occ;
        case ({pop, hs})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    // Exits toward IDLE look at the post-edge occupancy so IDLE is only ever
    // entered with an empty buffer, even when a pop or the last handshake
    // lands on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                if (!en) state_next = (occ_next != 2'd0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (en)                       state_next = RUN;
                else if (occ_next == 2'd0)    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge reset_r_n) begin
        if (!reset_r_n) begin
            state <= IDLE;
            occ   <= 2'd0;
        end else begin
            state <= state_next;
            occ   <= occ_next;
        end
    end

    // Simultaneous pop and handshake only happens at occ==1 (pop needs occ<2,
    // handshake needs occ>0), so the new word goes straight to the head.
    always_ff @(posedge rclk or negedge reset_r_n) begin
        if (!reset_r_n) begin
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            case ({pop, hs})
                2'b10: begin
                    if (occ == 2'd0) buf_head <= rdata;
                    else             buf_tail <= rdata;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                end
                2'b11: begin
                    buf_head <= rdata;
                end
                default: begin
                    buf_head <= buf_head;
                end
            endcase
        end
    end

`ifdef FIFO_RD_POP_CNT_EN
    always_ff @(posedge rclk or negedge reset_r_n) begin
        if (!reset_r_n) pop_cnt <= '0;
        else if (pop)   pop_cnt <= pop_cnt + CW'(1);
    end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - directed self-checking bench for fifo_rd_drain

module tb_fifo_rd_drain;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          reset_r_n;
    logic          en;
    logic          empty;
    logic [DW-1:0] rdata;
    logic          pop;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          idle;
`ifdef FIFO_RD_POP_CNT_EN
    logic [CW-1:0] pop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] hs_q[$];

    fifo_rd_drain #(.DW(DW), .CW(CW)) dut (
        .rclk      (rclk),
        .reset_r_n (reset_r_n),
        .en        (en),
        .empty     (empty),
        .rdata     (rdata),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .idle      (idle)
`ifdef FIFO_RD_POP_CNT_EN
        ,
        .pop_cnt   (pop_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    // FIFO model: pops at the clock edge, flags and head data refresh mid-cycle
    always @(posedge rclk) begin
        if (reset_r_n && pop) begin
            n_pops++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        if (reset_r_n && out_valid && out_ready) hs_q.push_back(out_data);
    end

    always @(negedge rclk) begin
        empty = (fq.size() == 0);
        rdata = (fq.size() == 0) ? 'x : fq[0];
    end

    task automatic tick();
        @(negedge rclk);
        #1;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        out_ready = 1'b0;
        reset_r_n = 1'b0;
        tick();
        tick();
        reset_r_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_r_n = 1'b0;
        #1;
        n_checks++; if (idle !== 1'b1)     begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (pop !== 1'b0)      begin n_fail++; $display("FAIL reset_pop got=%b exp=0", pop); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        tick();
        reset_r_n = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        en = 1'b1; out_ready = 1'b1;
        tick();
        fq.push_back(8'hA1); fq.push_back(8'hB2);
        tick();
        n_checks++; if (pop !== 1'b1) begin n_fail++; $display("FAIL stream_pop0 got=%b exp=1", pop); end
        tick();
        n_checks++; if (pop !== 1'b1) begin n_fail++; $display("FAIL stream_pop1 got=%b exp=1", pop); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin n_fail++; $display("FAIL stream_d0 got=%b/%h exp=1/a1", out_valid, out_data); end
        tick();
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL stream_pop2 got=%b exp=0", pop); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hB2) begin n_fail++; $display("FAIL stream_d1 got=%b/%h exp=1/b2", out_valid, out_data); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        fq.push_back(8'hC3); fq.push_back(8'hD4); fq.push_back(8'hE5);
        tick();
        tick();
        tick();
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL bp_pop_stop got=%b exp=0", pop); end
        n_checks++; if (out_data !== 8'hC3) begin n_fail++; $display("FAIL bp_head got=%h exp=c3", out_data); end
        tick();
        tick();
        n_checks++; if (out_data !== 8'hC3 || pop !== 1'b0) begin n_fail++; $display("FAIL bp_stable got=%h/%b exp=c3/0", out_data, pop); end
        n_checks++; if (fq.size() !== 1) begin n_fail++; $display("FAIL bp_fifo_left got=%0d exp=1", fq.size()); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_data !== 8'hD4 || pop !== 1'b1) begin n_fail++; $display("FAIL bp_resume got=%h/%b exp=d4/1", out_data, pop); end
        tick();
        n_checks++; if (out_data !== 8'hE5 || pop !== 1'b0) begin n_fail++; $display("FAIL bp_last got=%h/%b exp=e5/0", out_data, pop); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (pop !== 1'b0 || out_valid !== 1'b0 || ^out_data === 1'bx) begin
                n_fail++;
                $display("FAIL empty_cycle%0d got pop=%b valid=%b data=%h exp 0/0/known", i, pop, out_valid, out_data);
            end
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b0;
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
        tick(); tick(); tick();
        en = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++; if (pop !== 1'b0 || out_data !== 8'h22 || idle !== 1'b0) begin n_fail++; $display("FAIL drain_mid got pop=%b data=%h idle=%b exp 0/22/0", pop, out_data, idle); end
        tick();
        n_checks++; if (idle !== 1'b1 || out_valid !== 1'b0 || pop !== 1'b0) begin n_fail++; $display("FAIL drain_idle got idle=%b valid=%b pop=%b exp 1/0/0", idle, out_valid, pop); end
        n_checks++; if (fq.size() !== 1) begin n_fail++; $display("FAIL drain_no_pop got=%0d exp=1", fq.size()); end
        fq.push_back(8'h44);
        en = 1'b1; out_ready = 1'b0;
        tick();
        n_checks++; if (pop !== 1'b1) begin n_fail++; $display("FAIL rerun_pop got=%b exp=1", pop); end
        tick(); tick();
        en = 1'b0;
        tick();
        n_checks++; if (idle !== 1'b0 || pop !== 1'b0 || out_data !== 8'h33) begin n_fail++; $display("FAIL drain2 got idle=%b pop=%b data=%h exp 0/0/33", idle, pop, out_data); end
        fq.push_back(8'h55);
        en = 1'b1; out_ready = 1'b1;
        tick();
        n_checks++; if (pop !== 1'b1 || out_data !== 8'h44) begin n_fail++; $display("FAIL drain_reenable got pop=%b data=%h exp 1/44", pop, out_data); end
        en = 1'b0;
        tick();
        n_checks++; if (pop !== 1'b0 || out_data !== 8'h55) begin n_fail++; $display("FAIL drain3 got pop=%b data=%h exp 0/55", pop, out_data); end
        tick();
        n_checks++; if (idle !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain3_idle got idle=%b valid=%b exp 1/0", idle, out_valid); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; out_ready = 1'b0;
        fq.push_back(8'h66); fq.push_back(8'h77);
        tick(); tick(); tick();
        n_checks++; if (out_valid !== 1'b1 || pop !== 1'b0) begin n_fail++; $display("FAIL midrst_pre got valid=%b pop=%b exp 1/0", out_valid, pop); end
        reset_r_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || out_data !== 8'h00) begin n_fail++; $display("FAIL midrst_async got valid=%b idle=%b data=%h exp 0/1/00", out_valid, idle, out_data); end
        en = 1'b0;
        tick();
        reset_r_n = 1'b1;
        tick();
    endtask

    task automatic test_counter();
        int base;
        int cyc;
        do_reset();
        fq.delete();
        tick();
`ifdef FIFO_RD_POP_CNT_EN
        n_checks++; if (pop_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_reset got=%0d exp=0", pop_cnt); end
`endif
        hs_q.delete();
        base = n_pops;
        for (int i = 0; i < 17; i++) fq.push_back(8'h40 + 8'(i));
        en = 1'b1; out_ready = 1'b1;
        cyc = 0;
        while (hs_q.size() < 17 && cyc < 60) begin
            tick();
            cyc++;
        end
        n_checks++; if (hs_q.size() !== 17) begin n_fail++; $display("FAIL cnt_delivered got=%0d exp=17", hs_q.size()); end
        n_checks++; if (n_pops - base !== 17) begin n_fail++; $display("FAIL cnt_pops got=%0d exp=17", n_pops - base); end
        n_checks++; if (cyc > 21) begin n_fail++; $display("FAIL cnt_throughput got=%0d cycles exp<=21", cyc); end
        for (int i = 0; i < hs_q.size(); i++) begin
            n_checks++;
            if (hs_q[i] !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL cnt_order%0d got=%h exp=%h", i, hs_q[i], 8'h40 + 8'(i)); end
        end
`ifdef FIFO_RD_POP_CNT_EN
        n_checks++; if (pop_cnt !== 4'd1) begin n_fail++; $display("FAIL cnt_wrap got=%0d exp=1", pop_cnt); end
`endif
        en = 1'b0;
        tick(); tick();
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL cnt_idle got=%b exp=1", idle); end
    endtask

    initial begin
        en = 1'b0; out_ready = 1'b0; reset_r_n = 1'b0;
        empty = 1'b1; rdata = 'x;
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty();
        test_drain();
        test_reset_mid();
        fq.delete();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
